// File: rtl/aes_sbox_sub_engine.sv
// Time-multiplexed AES SubBytes engine: LANES forward/inverse S-box lookups per clock
// over a DATA_BYTES block, with valid/ready handshakes on input and output.
module aes_sbox_sub_engine #(
  parameter int DATA_BYTES = 16,
  parameter int LANES      = 4,
  parameter int INV_EN     = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [8*DATA_BYTES-1:0] in_data_i,
  input  logic                    inv_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [8*DATA_BYTES-1:0] out_data_o,
  output logic                    busy_o
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int STEPS = DATA_BYTES / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((DATA_BYTES < 1) || (LANES < 1) || ((DATA_BYTES % LANES) != 0)) begin : g_bad_cfg
    $error("aes_sbox_sub_engine: LANES must be >= 1 and divide DATA_BYTES");
  end

  // Byte b of each table sits at bits [2047-8*b -: 8] (entry 0x00 is the MSB byte).
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return FWD_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [W-1:0]    work, work_next;
  logic [CW-1:0]   cnt;
  logic            mode;
  logic            accept;
  int              pos;
  logic [7:0]      lane_in;

  assign in_ready_o  = (state == IDLE) || ((state == HOLD) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state == HOLD);
  assign busy_o      = (state == SUB);
  assign out_data_o  = work;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SUB;
      SUB:     if (cnt == LAST) state_next = HOLD;
      HOLD:    if (out_ready_i) state_next = accept ? SUB : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // One step rewrites LANES consecutive bytes of the work register in place.
  always_comb begin
    work_next = work;
    pos       = 0;
    lane_in   = '0;
    for (int l = 0; l < LANES; l++) begin
      pos     = int'(cnt) * LANES + l;
      lane_in = work[W - 1 - 8 * pos -: 8];
      work_next[W - 1 - 8 * pos -: 8] =
        ((INV_EN != 0) && mode) ? inv_sbox(lane_in) : fwd_sbox(lane_in);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      work <= '0;
      cnt  <= '0;
      mode <= 1'b0;
    end else if (accept) begin
      work <= in_data_i;
      cnt  <= '0;
      mode <= (INV_EN != 0) ? inv_i : 1'b0;
    end else if (state == SUB) begin
      work <= work_next;
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_sbox_sub_engine.sv
// Directed bench for aes_sbox_sub_engine: FIPS-197 vectors, handshakes, reset abort,
// and a LANES/DATA_BYTES/INV_EN sweep with latency checks.
module tb_aes_sbox_sub_engine;

  localparam logic [127:0] VEC    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_F  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ROW0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ROW0_F = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] ROW0_I = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] ALL63  = {16{8'h63}};
  localparam logic [127:0] ALLFB  = {16{8'hfb}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, inv = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  logic         sw_valid = 1'b0, sw_inv = 1'b0, sw_ready = 1'b1;
  logic [127:0] sw_data = '0;
  logic [4:0]   sw_ov, sw_ir, sw_bz;
  logic [127:0] od_l1, od_l16;
  logic [31:0]  od_k1, od_k2, od_k4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_sbox_sub_engine #(.DATA_BYTES(16), .LANES(4), .INV_EN(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .inv_i(inv), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .busy_o(busy));

  aes_sbox_sub_engine #(.DATA_BYTES(16), .LANES(1), .INV_EN(1)) dut_l1 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_ir[0]),
    .in_data_i(sw_data), .inv_i(sw_inv), .out_valid_o(sw_ov[0]), .out_ready_i(sw_ready),
    .out_data_o(od_l1), .busy_o(sw_bz[0]));

  aes_sbox_sub_engine #(.DATA_BYTES(16), .LANES(16), .INV_EN(1)) dut_l16 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_ir[1]),
    .in_data_i(sw_data), .inv_i(sw_inv), .out_valid_o(sw_ov[1]), .out_ready_i(sw_ready),
    .out_data_o(od_l16), .busy_o(sw_bz[1]));

  aes_sbox_sub_engine #(.DATA_BYTES(4), .LANES(1), .INV_EN(1)) dut_k1 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_ir[2]),
    .in_data_i(sw_data[127:96]), .inv_i(sw_inv), .out_valid_o(sw_ov[2]),
    .out_ready_i(sw_ready), .out_data_o(od_k1), .busy_o(sw_bz[2]));

  aes_sbox_sub_engine #(.DATA_BYTES(4), .LANES(2), .INV_EN(0)) dut_k2 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_ir[3]),
    .in_data_i(sw_data[127:96]), .inv_i(sw_inv), .out_valid_o(sw_ov[3]),
    .out_ready_i(sw_ready), .out_data_o(od_k2), .busy_o(sw_bz[3]));

  aes_sbox_sub_engine #(.DATA_BYTES(4), .LANES(4), .INV_EN(1)) dut_k4 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_ir[4]),
    .in_data_i(sw_data[127:96]), .inv_i(sw_inv), .out_valid_o(sw_ov[4]),
    .out_ready_i(sw_ready), .out_data_o(od_k4), .busy_o(sw_bz[4]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; counts edges until out_valid rises (bounded).
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Full single-block transaction on the main engine; inputs are scrambled after accept.
  task automatic run_block(input logic [127:0] d, input logic m, output logic [127:0] res,
                           output int lat);
    chk("pre_ready", in_ready, 1'b1);
    in_data = d; inv = m; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; inv = ~m;
    wait_out(lat);
    res = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic sweep(input string tag, input logic [127:0] d, input logic m,
                       input logic [127:0] e16, input logic [31:0] e4, input logic [31:0] e4_k2);
    int lat[5];
    logic [127:0] cap[5];
    for (int i = 0; i < 5; i++) begin lat[i] = 0; cap[i] = '0; end
    chk({tag, "_ready"}, sw_ir, 5'b11111);
    sw_data = d; sw_inv = m; sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0; sw_data = ~d; sw_inv = ~m;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (sw_ov[0] && lat[0] == 0) begin lat[0] = k; cap[0] = od_l1; end
      if (sw_ov[1] && lat[1] == 0) begin lat[1] = k; cap[1] = od_l16; end
      if (sw_ov[2] && lat[2] == 0) begin lat[2] = k; cap[2] = {96'b0, od_k1}; end
      if (sw_ov[3] && lat[3] == 0) begin lat[3] = k; cap[3] = {96'b0, od_k2}; end
      if (sw_ov[4] && lat[4] == 0) begin lat[4] = k; cap[4] = {96'b0, od_k4}; end
    end
    chk({tag, "_lat_l1"},  lat[0], 16);
    chk({tag, "_lat_l16"}, lat[1], 1);
    chk({tag, "_lat_k1"},  lat[2], 4);
    chk({tag, "_lat_k2"},  lat[3], 2);
    chk({tag, "_lat_k4"},  lat[4], 1);
    chk({tag, "_dat_l1"},  cap[0], e16);
    chk({tag, "_dat_l16"}, cap[1], e16);
    chk({tag, "_dat_k1"},  cap[2], {96'b0, e4});
    chk({tag, "_dat_k2"},  cap[3], {96'b0, e4_k2});
    chk({tag, "_dat_k4"},  cap[4], {96'b0, e4});
  endtask

  initial begin
    logic [127:0] res, fwd, blk;
    logic [127:0] bb_in[3], bb_exp[3], bb_out[3];
    int lat, seen, idx, nout;
    int acc_cyc[3], xfer_cyc[3];
    logic will_acc, will_xfer;

    // Reset state, then reset in the middle of a SUB
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", out_data, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1'b1);
    in_data = VEC; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", out_data, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", in_ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid || busy) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_ghost", seen, 0);

    // Forward FIPS-197 vector, latency and busy during SUB
    in_data = VEC; inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '1; inv = 1'b1;
    chk("fwd_busy", busy, 1'b1);
    chk("fwd_not_ready", in_ready, 1'b0);
    wait_out(lat);
    chk("fwd_lat", lat, 4);
    chk("fwd_data", out_data, VEC_F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("fwd_drop", out_valid, 1'b0);

    // Inverse round trip and table spot values
    run_block(VEC_F, 1'b1, res, lat);
    chk("inv_vec", res, VEC);
    chk("inv_lat", lat, 4);
    run_block(ALL63, 1'b1, res, lat);
    chk("inv_all63", res, '0);
    run_block(ROW0, 1'b0, res, lat);
    chk("fwd_row0", res, ROW0_F);
    run_block(ROW0, 1'b1, res, lat);
    chk("inv_row0", res, ROW0_I);

    // Every byte value through forward then inverse
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) blk[127 - 8 * j -: 8] = 8'(16 * k + j);
      run_block(blk, 1'b0, fwd, lat);
      run_block(fwd, 1'b1, res, lat);
      chk($sformatf("trip_%0d", k), res, blk);
    end

    // Backpressure: block A held for 10 cycles while block B waits
    in_data = VEC; inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = ROW0;
    wait_out(lat);
    chk("bp_lat", lat, 4);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, VEC_F);
      chk("bp_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_drop", out_valid, 1'b0);
    chk("bp_b_busy", busy, 1'b1);
    wait_out(lat);
    chk("bp_b_data", out_data, ROW0_F);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Back-to-back with in_valid and out_ready held high
    bb_in[0] = VEC;  bb_exp[0] = VEC_F;
    bb_in[1] = ROW0; bb_exp[1] = ROW0_F;
    bb_in[2] = ALL63; bb_exp[2] = ALLFB;
    for (int i = 0; i < 3; i++) begin
      bb_out[i] = '0; acc_cyc[i] = -1; xfer_cyc[i] = -2;
    end
    idx = 0; nout = 0;
    inv = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = bb_in[0];
    for (int cyc = 0; cyc < 80 && nout < 3; cyc++) begin
      will_acc  = in_valid && in_ready;
      will_xfer = out_valid && out_ready;
      if (will_xfer) begin bb_out[nout] = out_data; xfer_cyc[nout] = cyc; end
      @(posedge clk); #1;
      if (will_xfer) nout++;
      if (will_acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) in_data = bb_in[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_count", nout, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_data_%0d", i), bb_out[i], bb_exp[i]);
    chk("b2b_acc_b", acc_cyc[1], xfer_cyc[0]);
    chk("b2b_acc_c", acc_cyc[2], xfer_cyc[1]);
    @(posedge clk); #1;
    chk("b2b_idle", in_ready, 1'b1);

    // Parameter sweep, including INV_EN=0 ignoring inv
    sweep("sw_fwd", VEC, 1'b0, VEC_F, 32'h638293c3, 32'h638293c3);
    sweep("sw_inv", '0, 1'b1, {16{8'h52}}, 32'h52525252, 32'h63636363);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
